pri_enc_iter: RTL



---
 rtl/npu_pkg.sv | 17 +
 rtl/pri_enc_lsb.sv | 28 ++
 rtl/pri_enc_iter.sv | 103 ++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared types and sizing for the NPU sparse-match datapath.
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 8
`endif

package npu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Sparsemap width per slice and the matching bit-index width.
   localparam int unsigned PS_SIZE = `PREFIX_SUM_SIZE;
   localparam int unsigned PS_AW   = (PS_SIZE > 1) ? $clog2(PS_SIZE) : 1;

endpackage

// File: rtl/pri_enc_lsb.sv
// Combinational find-first-set: index, one-hot select and any flag of the
// lowest set bit of req_i. Index and select are zero when nothing is set.
module pri_enc_lsb #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  req_i,
   output logic [AW-1:0] idx_o,
   output logic [W-1:0]  sel_o,
   output logic          any_o
);

   // Scan from MSB down so the lowest set bit is the last one written.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      idx_o = '0;
      sel_o = '0;
      any_o = |req_i;
      for (int i = int'(W) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o    = AW'(i);
            sel_o    = '0;
            sel_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pri_enc_iter.sv
// Sparse-match iterator: ANDs an IFM and a filter sparsemap, then emits one
// matching bit index per non-held cycle, lowest first, until the slice is done.
module pri_enc_iter
   import npu_pkg::*;
#(
   parameter int unsigned PREFIX_SUM_SIZE = npu_pkg::PS_SIZE,
   parameter int unsigned AW = (PREFIX_SUM_SIZE > 1) ? $clog2(PREFIX_SUM_SIZE) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       load_i,
   input  logic [PREFIX_SUM_SIZE-1:0] ifm_sparsemap_i,
   input  logic [PREFIX_SUM_SIZE-1:0] filt_sparsemap_i,
   input  logic                       last_slice_i,
   input  logic                       hold_i,
   output logic                       ready_o,
   output logic                       match_valid_o,
   output logic [AW-1:0]              match_addr_o,
   output logic                       pri_enc_end_o,
   output logic                       chunk_end_o,
   output logic [PREFIX_SUM_SIZE-1:0] rd_sparsemap_o
);

   state_e                     r_state;
   state_e                     w_state_nxt;
   logic [PREFIX_SUM_SIZE-1:0] r_rem;
   logic [PREFIX_SUM_SIZE-1:0] r_ifm;
   logic                       r_last;

   logic [AW-1:0]              w_enc;
   logic [PREFIX_SUM_SIZE-1:0] w_sel;
   logic                       w_any;
   logic                       w_run;
   logic                       w_end;
   logic                       w_accept;
   logic                       w_advance;

   pri_enc_lsb #(
      .W  (PREFIX_SUM_SIZE),
      .AW (AW)
   ) u_pri_enc_lsb (
      .req_i (r_rem),
      .idx_o (w_enc),
      .sel_o (w_sel),
      .any_o (w_any)
   );

   assign w_run     = (r_state == RUN);
   // Last cycle of a slice: at most one bit left, which also covers an empty map.
   assign w_end     = w_run && ((r_rem & ~w_sel) == '0);
   assign w_advance = w_run && !hold_i;

   // Ready in IDLE regardless of hold; in RUN only on an unstalled final cycle,
   // which lets the next slice follow with no bubble.
   assign ready_o   = !w_run || (w_end && !hold_i);
   assign w_accept  = load_i && ready_o;

   assign match_valid_o  = w_run && w_any;
   assign match_addr_o   = w_run ? w_enc : '0;
   assign pri_enc_end_o  = w_end;
   assign chunk_end_o    = w_end && r_last;
   assign rd_sparsemap_o = w_run ? r_ifm : '0;

   // Next-state decode: a held RUN slice stays put; IDLE ignores hold.
   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         w_state_nxt = RUN;
      end else if (w_advance && w_end) begin
         w_state_nxt = IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= w_state_nxt;
      end
   end

   // Slice registers: load on accept, otherwise strip the lowest match each unheld cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rem  <= '0;
         r_ifm  <= '0;
         r_last <= 1'b0;
      end else if (w_accept) begin
         r_rem  <= ifm_sparsemap_i & filt_sparsemap_i;
         r_ifm  <= ifm_sparsemap_i;
         r_last <= last_slice_i;
      end else if (w_advance) begin
         r_rem <= r_rem & ~w_sel;
         if (w_end) begin
            r_ifm  <= '0;
            r_last <= 1'b0;
         end
      end
   end

endmodule
